// File: rtl/cart_mbc_if.sv
// Cartridge bus between the gb core (master) and the cartridge mapper (slave).
// Carries the CPU/DMA address, read and write strobes, write data and read data.
// The bus has no handshake. A read returns data one clk after cart_rd.
interface cart_mbc_if;
  logic [15:0] cart_addr;
  logic        cart_rd;
  logic        cart_wr;
  logic [7:0]  cart_di;
  logic [7:0]  cart_do;

  modport master (output cart_addr, cart_rd, cart_wr, cart_di, input cart_do);
  modport slave  (input cart_addr, cart_rd, cart_wr, cart_di, output cart_do);
endinterface

// File: rtl/cart_mbc.sv
// Cartridge memory bank controller (none/MBC1/MBC5): decodes register writes, maps CPU addresses to ROM/RAM stores.
// Latency: store addresses and strobes are combinational; cart_do is valid one clk after cart_rd.
// Backpressure: none. Every strobe is serviced in its own cycle.
// Ports: clk/reset; bus (slave side of cart_mbc_if); ld_* loader snoop; rom_* / ram_* store side;
//        cart_unsupported flags an unrecognised header type byte.
module cart_mbc #(
  parameter int ROM_AW = 20,
  parameter int RAM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  cart_mbc_if.slave         bus,
  input  logic              ld_we,
  input  logic [ROM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [7:0]        rom_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              cart_unsupported
);

  localparam int RBW = ROM_AW - 14;  // ROM bank number width

  typedef enum logic [1:0] {MAP_NONE, MAP_MBC1, MAP_MBC5} map_t;
  typedef enum logic [1:0] {SRC_FF, SRC_ROM, SRC_RAM} src_t;

  // Header bytes come from the image, not the CPU. Reset leaves them alone, so they start at zero on power-up.
  logic [7:0] r_type     = 8'h00;
  logic [7:0] r_rom_size = 8'h00;
  logic [7:0] r_ram_size = 8'h00;

  always_ff @(posedge clk) begin
    if (ld_we) begin
      if (ld_addr == ROM_AW'('h147)) r_type     <= ld_data;
      if (ld_addr == ROM_AW'('h148)) r_rom_size <= ld_data;
      if (ld_addr == ROM_AW'('h149)) r_ram_size <= ld_data;
    end
  end

  map_t w_map;
  logic w_unsup;
  always_comb begin
    w_map   = MAP_NONE;
    w_unsup = 1'b0;
    case (r_type)
      8'h00, 8'h08, 8'h09:                      w_map = MAP_NONE;
      8'h01, 8'h02, 8'h03:                      w_map = MAP_MBC1;
      8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E: w_map = MAP_MBC5;
      default:                                  w_unsup = 1'b1;
    endcase
  end
  assign cart_unsupported = w_unsup;

  // The ROM bank mask covers (2 << rom_size) banks. It saturates at the bank count the store can hold.
  logic [RBW-1:0] w_rom_mask;
  always_comb begin
    if ({24'd0, r_rom_size} >= 32'(RBW - 1)) w_rom_mask = '1;
    else                                     w_rom_mask = RBW'((32'd2 << r_rom_size) - 32'd1);
  end

  // RAM size code to log2(bytes). Unknown codes are treated as "no RAM".
  logic       w_ram_present;
  logic [4:0] w_ram_log2;
  logic [RAM_AW-1:0] w_ram_mask;
  always_comb begin
    w_ram_present = 1'b1;
    w_ram_log2    = 5'd0;
    case (r_ram_size)
      8'h01:   w_ram_log2 = 5'd11;
      8'h02:   w_ram_log2 = 5'd13;
      8'h03:   w_ram_log2 = 5'd15;
      8'h04:   w_ram_log2 = 5'd17;
      8'h05:   w_ram_log2 = 5'd16;
      default: w_ram_present = 1'b0;
    endcase
    if ({27'd0, w_ram_log2} >= 32'(RAM_AW)) w_ram_mask = '1;
    else                                    w_ram_mask = RAM_AW'((32'd1 << w_ram_log2) - 32'd1);
  end

  // Bank registers. MBC1 uses bank1[4:0] and bank2[1:0]. MBC5 uses all the bits.
  logic       r_ram_en;
  logic [8:0] r_bank1;
  logic [3:0] r_bank2;
  logic       r_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_en <= 1'b0;
      r_bank1  <= 9'd1;
      r_bank2  <= 4'd0;
      r_mode   <= 1'b0;
    end else if (bus.cart_wr && !bus.cart_addr[15]) begin
      case (w_map)
        MAP_MBC1: begin
          case (bus.cart_addr[14:13])
            2'b00: r_ram_en <= (bus.cart_di[3:0] == 4'hA);
            // MBC1 cannot select bank 0 in the upper window, so a write of 0 selects bank 1.
            2'b01: r_bank1  <= (bus.cart_di[4:0] == 5'd0) ? 9'd1 : {4'd0, bus.cart_di[4:0]};
            2'b10: r_bank2  <= {2'b00, bus.cart_di[1:0]};
            default: r_mode <= bus.cart_di[0];
          endcase
        end
        MAP_MBC5: begin
          case (bus.cart_addr[14:13])
            2'b00: r_ram_en <= (bus.cart_di[3:0] == 4'hA);
            2'b01: begin
              if (bus.cart_addr[12]) r_bank1[8]   <= bus.cart_di[0];
              else                   r_bank1[7:0] <= bus.cart_di;
            end
            2'b10: r_bank2 <= bus.cart_di[3:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Address mapping
  logic [8:0] w_rom_bank;
  logic [3:0] w_ram_bank;
  always_comb begin
    w_rom_bank = 9'd0;
    w_ram_bank = 4'd0;
    case (w_map)
      MAP_MBC1: begin
        // In mode 1, bank2 also selects the high bits for the lower ROM window and for RAM.
        if (bus.cart_addr[14]) w_rom_bank = {2'b00, r_bank2[1:0], r_bank1[4:0]};
        else if (r_mode)       w_rom_bank = {2'b00, r_bank2[1:0], 5'd0};
        w_ram_bank = r_mode ? {2'b00, r_bank2[1:0]} : 4'd0;
      end
      MAP_MBC5: begin
        if (bus.cart_addr[14]) w_rom_bank = r_bank1;
        w_ram_bank = r_bank2;
      end
      default: w_rom_bank = {8'd0, bus.cart_addr[14]};
    endcase
  end

  logic [RBW-1:0] w_bank_sel;
  logic [16:0]    w_ram_full;
  assign w_bank_sel = RBW'(w_rom_bank);
  assign rom_addr   = {w_bank_sel & w_rom_mask, bus.cart_addr[13:0]};
  assign w_ram_full = {w_ram_bank, bus.cart_addr[12:0]};
  assign ram_addr   = RAM_AW'(w_ram_full) & w_ram_mask;

  // Strobes. A cycle with both rd and wr is treated as a write. Reset holds every store strobe low.
  logic w_rom_win, w_ram_win, w_ram_access, w_rd_ok;
  assign w_rom_win    = !bus.cart_addr[15];
  assign w_ram_win    = (bus.cart_addr[15:13] == 3'b101);
  assign w_ram_access = w_ram_present && ((w_map == MAP_NONE) || r_ram_en);
  assign w_rd_ok      = bus.cart_rd && !bus.cart_wr && !reset;
  assign rom_rd       = w_rd_ok && w_rom_win;
  assign ram_rd       = w_rd_ok && w_ram_win && w_ram_access;
  assign ram_wr       = bus.cart_wr && w_ram_win && w_ram_access && !reset;
  assign ram_wdata    = bus.cart_di;

  // The read source is registered next to the synchronous store read, so cart_do follows the data.
  src_t r_src;
  always_ff @(posedge clk) begin
    if (reset)       r_src <= SRC_FF;
    else if (rom_rd) r_src <= SRC_ROM;
    else if (ram_rd) r_src <= SRC_RAM;
    else             r_src <= SRC_FF;
  end

  always_comb begin
    case (r_src)
      SRC_ROM: bus.cart_do = rom_rdata;
      SRC_RAM: bus.cart_do = ram_rdata;
      default: bus.cart_do = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_cart_mbc.sv
// Directed, table-driven bench for cart_mbc with behavioural ROM/RAM stores.
// Latency: reads are checked on the cycle after the strobe.
// Backpressure: none.
module tb_cart_mbc;

  logic        clk;
  logic        reset;
  logic        ld_we;
  logic [19:0] ld_addr;
  logic [7:0]  ld_data;
  logic [19:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_rdata;
  logic [14:0] ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        cart_unsupported;

  cart_mbc_if cbus ();

  cart_mbc #(.ROM_AW(20), .RAM_AW(15)) dut (
    .clk(clk), .reset(reset), .bus(cbus),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_rdata(rom_rdata),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cart_unsupported(cart_unsupported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_pat(input logic [19:0] a);
    return a[7:0] ^ a[19:12] ^ 8'hA5;
  endfunction

  // ROM model: synchronous read of a fixed pattern.
  always @(posedge clk) if (rom_rd) rom_rdata <= rom_pat(rom_addr);

  // RAM model: synchronous read/write array.
  logic [7:0] ram_mem [0:32767];
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= ram_mem[ram_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef enum int {K_HDR, K_RST, K_WR, K_WR_RAM, K_RD_ROM, K_RD_RAM, K_RD_FF, K_UNS} kind_t;
  typedef struct {
    kind_t       kind;
    logic [15:0] addr;
    logic [7:0]  di;
    logic [19:0] exp_addr;
    logic [7:0]  exp_do;
    logic        exp_stb;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input kind_t k, input logic [15:0] a, input logic [7:0] d,
                     input logic [19:0] ea, input logic [7:0] ed, input logic es, input string nm);
    vec_t v;
    v.kind = k; v.addr = a; v.di = d; v.exp_addr = ea; v.exp_do = ed; v.exp_stb = es; v.name = nm;
    vq.push_back(v);
  endtask

  // Each step starts 1 time unit after a rising edge and ends at the same point after a later edge.
  task automatic run(input vec_t v);
    case (v.kind)
      K_HDR: begin
        ld_we = 1'b1; ld_addr = {4'd0, v.addr}; ld_data = v.di;
        @(posedge clk); #1;
        ld_we = 1'b0;
      end
      K_RST: begin
        reset = 1'b1;
        @(posedge clk); #1;
        check({v.name, "_do"}, {24'd0, cbus.cart_do}, 32'hFF);
        reset = 1'b0;
      end
      K_WR: begin
        cbus.cart_wr = 1'b1; cbus.cart_addr = v.addr; cbus.cart_di = v.di;
        @(posedge clk); #1;
        cbus.cart_wr = 1'b0;
      end
      K_WR_RAM: begin
        cbus.cart_wr = 1'b1; cbus.cart_addr = v.addr; cbus.cart_di = v.di;
        #1;
        check({v.name, "_wr"}, {31'd0, ram_wr}, {31'd0, v.exp_stb});
        if (v.exp_stb) check({v.name, "_addr"}, {17'd0, ram_addr}, {12'd0, v.exp_addr});
        @(posedge clk); #1;
        cbus.cart_wr = 1'b0;
      end
      K_RD_ROM: begin
        cbus.cart_rd = 1'b1; cbus.cart_addr = v.addr;
        #1;
        check({v.name, "_rd"}, {31'd0, rom_rd}, 32'd1);
        check({v.name, "_addr"}, {12'd0, rom_addr}, {12'd0, v.exp_addr});
        @(posedge clk); #1;
        cbus.cart_rd = 1'b0;
        check({v.name, "_do"}, {24'd0, cbus.cart_do}, {24'd0, rom_pat(v.exp_addr)});
      end
      K_RD_RAM: begin
        cbus.cart_rd = 1'b1; cbus.cart_addr = v.addr;
        #1;
        check({v.name, "_rd"}, {31'd0, ram_rd}, 32'd1);
        check({v.name, "_addr"}, {17'd0, ram_addr}, {12'd0, v.exp_addr});
        @(posedge clk); #1;
        cbus.cart_rd = 1'b0;
        check({v.name, "_do"}, {24'd0, cbus.cart_do}, {24'd0, v.exp_do});
      end
      K_RD_FF: begin
        cbus.cart_rd = 1'b1; cbus.cart_addr = v.addr;
        #1;
        check({v.name, "_rd"}, {31'd0, ram_rd}, 32'd0);
        @(posedge clk); #1;
        cbus.cart_rd = 1'b0;
        check({v.name, "_do"}, {24'd0, cbus.cart_do}, 32'hFF);
      end
      default: begin
        check(v.name, {31'd0, cart_unsupported}, {31'd0, v.exp_stb});
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    cbus.cart_rd = 1'b1; cbus.cart_wr = 1'b0; cbus.cart_addr = 16'h0000; cbus.cart_di = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_rd", {31'd0, rom_rd}, 32'd0);
    check("rst_do", {24'd0, cbus.cart_do}, 32'hFF);
    check("rst_unsup", {31'd0, cart_unsupported}, 32'd0);
    reset = 1'b0; cbus.cart_rd = 1'b0;

    // MBC1, 1MB ROM, 32KB RAM
    add(K_HDR, 16'h0147, 8'h01, 0, 0, 0, "h_type");
    add(K_HDR, 16'h0148, 8'h05, 0, 0, 0, "h_rom");
    add(K_HDR, 16'h0149, 8'h03, 0, 0, 0, "h_ram");
    add(K_UNS, 0, 0, 0, 0, 1'b0, "m1_unsup");
    add(K_WR,  16'h2000, 8'h00, 0, 0, 0, "m1_b0");
    add(K_RD_ROM, 16'h4000, 0, 20'h04000, 0, 1, "m1_b0_is_1");
    add(K_RD_FF,  16'hA000, 0, 0, 0, 0, "m1_ram_off");
    add(K_WR,  16'h2000, 8'h1F, 0, 0, 0, "m1_b1f");
    add(K_WR,  16'h4000, 8'h01, 0, 0, 0, "m1_b2_1");
    add(K_RD_ROM, 16'h7FFF, 0, 20'hFFFFF, 0, 1, "m1_top");
    add(K_RD_ROM, 16'h0000, 0, 20'h00000, 0, 1, "m1_lo_m0");
    add(K_WR,  16'h6000, 8'h01, 0, 0, 0, "m1_mode1");
    add(K_RD_ROM, 16'h0000, 0, 20'h80000, 0, 1, "m1_lo_m1");
    add(K_RD_ROM, 16'h4000, 0, 20'hFC000, 0, 1, "m1_hi_m1");
    add(K_WR,  16'h0000, 8'h0A, 0, 0, 0, "m1_en");
    add(K_WR,  16'h4000, 8'h02, 0, 0, 0, "m1_b2_2");
    add(K_RD_ROM, 16'h0123, 0, 20'h00123, 0, 1, "m1_lo_mask");
    add(K_WR_RAM, 16'hA123, 8'h3C, 20'h04123, 0, 1, "m1_ramwr");
    add(K_RD_RAM, 16'hA123, 0, 20'h04123, 8'h3C, 1, "m1_ramrd");
    add(K_WR,  16'h0000, 8'h00, 0, 0, 0, "m1_dis");
    add(K_RD_FF,  16'hA123, 0, 0, 0, 0, "m1_ram_dis");
    add(K_WR,  16'h2000, 8'h00, 0, 0, 0, "m1_b0b");
    add(K_RD_ROM, 16'h5555, 0, 20'h05555, 0, 1, "m1_hi_mask");
    // MBC5
    add(K_RST, 0, 0, 0, 0, 0, "m5_rst");
    add(K_HDR, 16'h0147, 8'h19, 0, 0, 0, "h_type5");
    add(K_UNS, 0, 0, 0, 0, 1'b0, "m5_unsup");
    add(K_RD_ROM, 16'h4000, 0, 20'h04000, 0, 1, "m5_rstbank");
    add(K_WR,  16'h2000, 8'h00, 0, 0, 0, "m5_b0");
    add(K_RD_ROM, 16'h4000, 0, 20'h00000, 0, 1, "m5_bank0");
    add(K_WR,  16'h2000, 8'h05, 0, 0, 0, "m5_b5");
    add(K_RD_ROM, 16'h7000, 0, 20'h17000, 0, 1, "m5_bank5");
    add(K_WR,  16'h3000, 8'h01, 0, 0, 0, "m5_b8");
    add(K_RD_ROM, 16'h4000, 0, 20'h14000, 0, 1, "m5_b105");
    add(K_WR,  16'h2000, 8'h00, 0, 0, 0, "m5_b0b");
    add(K_RD_ROM, 16'h4000, 0, 20'h00000, 0, 1, "m5_b100");
    add(K_WR,  16'h6000, 8'h01, 0, 0, 0, "m5_nomode");
    add(K_RD_ROM, 16'h0100, 0, 20'h00100, 0, 1, "m5_lo");
    add(K_WR,  16'h0000, 8'h0A, 0, 0, 0, "m5_en");
    add(K_WR,  16'h4000, 8'h03, 0, 0, 0, "m5_rb3");
    add(K_WR_RAM, 16'hA010, 8'h99, 20'h06010, 0, 1, "m5_ramwr");
    add(K_RD_RAM, 16'hA010, 0, 20'h06010, 8'h99, 1, "m5_ramrd");
    // No MBC
    add(K_RST, 0, 0, 0, 0, 0, "n_rst");
    add(K_HDR, 16'h0147, 8'h00, 0, 0, 0, "h_type0");
    add(K_HDR, 16'h0149, 8'h00, 0, 0, 0, "h_ram0");
    add(K_UNS, 0, 0, 0, 0, 1'b0, "n_unsup");
    add(K_WR,  16'h2000, 8'h05, 0, 0, 0, "n_b5");
    add(K_RD_ROM, 16'h4000, 0, 20'h04000, 0, 1, "n_flat4");
    add(K_RD_ROM, 16'h0123, 0, 20'h00123, 0, 1, "n_flat0");
    add(K_RD_ROM, 16'h7ABC, 0, 20'h07ABC, 0, 1, "n_flat7");
    add(K_RD_FF,  16'hA000, 0, 0, 0, 0, "n_noram");
    add(K_WR_RAM, 16'hA000, 8'h11, 0, 0, 0, "n_noramwr");
    add(K_HDR, 16'h0147, 8'hFC, 0, 0, 0, "h_fc");
    add(K_UNS, 0, 0, 0, 0, 1'b1, "n_unsup_fc");
    add(K_HDR, 16'h0147, 8'h1E, 0, 0, 0, "h_1e");
    add(K_UNS, 0, 0, 0, 0, 1'b0, "n_unsup_1e");
    add(K_HDR, 16'h0147, 8'h04, 0, 0, 0, "h_04");
    add(K_UNS, 0, 0, 0, 0, 1'b1, "n_unsup_04");
    add(K_HDR, 16'h0147, 8'h08, 0, 0, 0, "h_08");
    add(K_HDR, 16'h0149, 8'h02, 0, 0, 0, "h_ram8k");
    add(K_WR_RAM, 16'hB234, 8'h5A, 20'h01234, 0, 1, "n_ramwr");
    add(K_RD_RAM, 16'hB234, 0, 20'h01234, 8'h5A, 1, "n_ramrd");
    // Set up for the hand-written sequences
    add(K_HDR, 16'h0147, 8'h01, 0, 0, 0, "h_type1");
    add(K_HDR, 16'h0149, 8'h03, 0, 0, 0, "h_ram32k");
    add(K_RST, 0, 0, 0, 0, 0, "s_rst");
    add(K_WR,  16'h0000, 8'h0A, 0, 0, 0, "s_en");

    foreach (vq[i]) run(vq[i]);
    vq.delete();

    // Read and write in the same cycle: the write goes through and the read returns FF.
    cbus.cart_rd = 1'b1; cbus.cart_wr = 1'b1; cbus.cart_addr = 16'hA124; cbus.cart_di = 8'h77;
    #1;
    check("rw_ramwr", {31'd0, ram_wr}, 32'd1);
    check("rw_ramrd", {31'd0, ram_rd}, 32'd0);
    @(posedge clk); #1;
    cbus.cart_rd = 1'b0; cbus.cart_wr = 1'b0;
    check("rw_do", {24'd0, cbus.cart_do}, 32'hFF);
    add(K_RD_RAM, 16'hA124, 0, 20'h00124, 8'h77, 1, "rw_readback");
    add(K_WR,  16'h2000, 8'h03, 0, 0, 0, "r_b3");
    add(K_WR,  16'h6000, 8'h01, 0, 0, 0, "r_mode");
    add(K_WR,  16'h4000, 8'h03, 0, 0, 0, "r_b2");
    foreach (vq[i]) run(vq[i]);
    vq.delete();

    // Reset in the same cycle as a ROM read, while the loader rewrites the RAM size to 8KB.
    cbus.cart_rd = 1'b1; cbus.cart_addr = 16'h4000; reset = 1'b1;
    ld_we = 1'b1; ld_addr = 20'h00149; ld_data = 8'h02;
    #1;
    check("mr_rom_rd", {31'd0, rom_rd}, 32'd0);
    @(posedge clk); #1;
    check("mr_do", {24'd0, cbus.cart_do}, 32'hFF);
    reset = 1'b0; cbus.cart_rd = 1'b0; ld_we = 1'b0;
    add(K_RD_ROM, 16'h4000, 0, 20'h04000, 0, 1, "mr_bank1");
    add(K_RD_FF,  16'hA000, 0, 0, 0, 0, "mr_ramen0");
    add(K_WR,  16'h2000, 8'h02, 0, 0, 0, "mr_b2");
    add(K_RD_ROM, 16'h4000, 0, 20'h08000, 0, 1, "mr_still_mbc1");
    add(K_WR,  16'h0000, 8'h0A, 0, 0, 0, "mr_en");
    add(K_WR,  16'h6000, 8'h01, 0, 0, 0, "mr_mode");
    add(K_WR,  16'h4000, 8'h03, 0, 0, 0, "mr_rb3");
    add(K_WR_RAM, 16'hA123, 8'h42, 20'h00123, 0, 1, "mr_ram8k");
    foreach (vq[i]) run(vq[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
